// File: rtl/bank_rotator_if.sv
// Write-side bundle of bank_rotator: per-channel input beats in, per-bank write ports out.
interface bank_rotator_if #(
  parameter int CHANNEL_NUMBER    = 3,
  parameter int CHANNEL_BANDWIDTH = 128,
  parameter int BLOCK_DEPTH       = 480
);
  localparam int AW    = $clog2(BLOCK_DEPTH);
  localparam int SEL_W = $clog2(CHANNEL_NUMBER);

  logic                                             I_valid;
  logic                                             I_frame_start;
  logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] I_data;
  logic [CHANNEL_NUMBER-1:0]                        O_we;
  logic [CHANNEL_NUMBER-1:0][AW-1:0]                O_addr;
  logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] O_data;
  logic                                             O_block_done;
  logic [SEL_W-1:0]                                 O_seg_idx;

  modport master (
    output I_valid, I_frame_start, I_data,
    input  O_we, O_addr, O_data, O_block_done, O_seg_idx
  );

  modport slave (
    input  I_valid, I_frame_start, I_data,
    output O_we, O_addr, O_data, O_block_done, O_seg_idx
  );
endinterface

// File: rtl/bank_rotator.sv
// Spreads CHANNEL_NUMBER parallel beat streams over as many RAM banks, rotating the
// channel-to-bank mapping once per segment so every bank sees a full block of addresses.
module bank_rotator #(
  parameter int CHANNEL_NUMBER    = 3,
  parameter int CHANNEL_BANDWIDTH = 128,
  parameter int BLOCK_DEPTH       = 480,
  parameter int ROTATE            = 1
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  bank_rotator_if.slave bus
);
  localparam int SEG_DEPTH = BLOCK_DEPTH / CHANNEL_NUMBER;
  localparam int AW        = $clog2(BLOCK_DEPTH);
  localparam int SEL_W     = $clog2(CHANNEL_NUMBER);

  localparam logic [AW-1:0]    SEG_LAST = AW'(SEG_DEPTH - 1);
  localparam logic [AW-1:0]    G_LAST   = AW'(BLOCK_DEPTH - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(CHANNEL_NUMBER - 1);

  // Segment base address ch*SEG_DEPTH built from compares and additions only.
  function automatic logic [AW-1:0] seg_base(input logic [SEL_W-1:0] ch);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 1; i < CHANNEL_NUMBER; i++) begin
      if (SEL_W'(i) <= ch) acc = acc + AW'(SEG_DEPTH);
    end
    return acc;
  endfunction

  logic [AW-1:0]    seg_pos;
  logic [SEL_W-1:0] seg_idx;
  logic [AW-1:0]    g_cnt;

  logic [AW-1:0]    cur_pos;
  logic [SEL_W-1:0] cur_idx;
  logic [AW-1:0]    cur_g;
  logic             last_p0;

  logic [CHANNEL_NUMBER-1:0][AW-1:0]                addr_p0;
  logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] data_p0;

  // A frame start restarts the block on this very beat.
  assign cur_pos = bus.I_frame_start ? '0 : seg_pos;
  assign cur_idx = bus.I_frame_start ? '0 : seg_idx;
  assign cur_g   = bus.I_frame_start ? '0 : g_cnt;
  assign last_p0 = (cur_g == G_LAST);

  for (genvar b = 0; b < CHANNEL_NUMBER; b++) begin : g_bank
    if (ROTATE != 0) begin : g_rot
      localparam logic [SEL_W-1:0] B_SEL  = SEL_W'(b);
      localparam logic [SEL_W-1:0] B_WRAP = SEL_W'(b + CHANNEL_NUMBER);
      logic [SEL_W-1:0] src_ch;

      // Bank b is fed by channel (b - seg_idx) mod CHANNEL_NUMBER.
      assign src_ch     = (B_SEL >= cur_idx) ? (B_SEL - cur_idx) : (B_WRAP - cur_idx);
      assign data_p0[b] = bus.I_data[src_ch];
      assign addr_p0[b] = seg_base(src_ch) + cur_pos;
    end else begin : g_dir
      assign data_p0[b] = bus.I_data[b];
      assign addr_p0[b] = cur_g;
    end
  end

  // ---- p0 -> output register boundary (latency 1) ----
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      seg_pos          <= '0;
      seg_idx          <= '0;
      g_cnt            <= '0;
      bus.O_we         <= '0;
      bus.O_addr       <= '0;
      bus.O_data       <= '0;
      bus.O_block_done <= 1'b0;
      bus.O_seg_idx    <= '0;
    end else begin
      bus.O_we         <= {CHANNEL_NUMBER{bus.I_valid}};
      bus.O_block_done <= bus.I_valid && last_p0;
      if (bus.I_valid) begin
        bus.O_addr    <= addr_p0;
        bus.O_data    <= data_p0;
        bus.O_seg_idx <= cur_idx;
        g_cnt         <= last_p0 ? '0 : cur_g + 1'b1;
        if (cur_pos == SEG_LAST) begin
          seg_pos <= '0;
          seg_idx <= (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;
        end else begin
          seg_pos <= cur_pos + 1'b1;
          seg_idx <= cur_idx;
        end
      end else if (bus.I_frame_start) begin
        seg_pos <= '0;
        seg_idx <= '0;
        g_cnt   <= '0;
      end
    end
  end
endmodule
